// File: rtl/register_file_mp.sv
// Parametrised multi-read-port register file with a hardwired zero register,
// write-to-read bypass, optional registered reads and a sequential bulk-clear engine.
module register_file_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int REG_READ = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             RegWrite,
  input  logic [$clog2(DEPTH)-1:0]         write_address,
  input  logic [WIDTH-1:0]                 write_data,
  input  logic [NREAD*$clog2(DEPTH)-1:0]   read_address,
  output logic [NREAD*WIDTH-1:0]           read_data,
  input  logic                             clear_req,
  output logic                             clear_busy,
  output logic                             clear_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [AW-1:0]    cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_en;

  assign wr_en = RegWrite && !clear_busy &&
                 !((ZERO_REG != 0) && (write_address == '0));

  // Clear engine: one register zeroed per cycle, stops on the last index without wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      clear_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state      <= CLEAR;
            cnt        <= '0;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == AW'(DEPTH - 1)) begin
            state      <= IDLE;
            clear_busy <= 1'b0;
            clear_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      mem[write_address] <= write_data;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_read
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] value;

    assign addr = read_address[p*AW +: AW];

    always_comb begin
      if ((ZERO_REG != 0) && (addr == '0)) begin
        value = '0;
      end else if ((BYPASS != 0) && wr_en && (write_address == addr)) begin
        value = write_data;
      end else begin
        value = mem[addr];
      end
    end

    if (REG_READ != 0) begin : g_reg
      logic [WIDTH-1:0] q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          q <= '0;
        end else begin
          q <= value;
        end
      end

      assign read_data[p*WIDTH +: WIDTH] = q;
    end else begin : g_comb
      assign read_data[p*WIDTH +: WIDTH] = value;
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp in its default configuration: vector table
// for read/write/bypass behaviour plus hand-written clear-engine sequences.
module tb_register_file_mp;

  logic        clk;
  logic        rst;
  logic        reg_write;
  logic [4:0]  write_address;
  logic [31:0] write_data;
  logic [4:0]  ra0, ra1;
  logic [63:0] read_data;
  logic        clear_req;
  logic        clear_busy;
  logic        clear_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [11];

  register_file_mp dut (
    .clk           (clk),
    .rst           (rst),
    .RegWrite      (reg_write),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address  ({ra1, ra0}),
    .read_data     (read_data),
    .clear_req     (clear_req),
    .clear_busy    (clear_busy),
    .clear_done    (clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] a0, input logic [4:0] a1);
    reg_write     = we;
    write_address = wa;
    write_data    = wd;
    ra0           = a0;
    ra1           = a1;
  endtask

  // Observes a clear sequence for a fixed window after clear_req was raised,
  // optionally re-requesting or writing at chosen cycle indices.
  task automatic clear_window(input int second_req_at, input int write_at,
                              input logic [4:0] wa, input logic [31:0] wd,
                              output int busy_cnt, output int done_cnt,
                              output int last_busy, output int done_at);
    busy_cnt  = 0;
    done_cnt  = 0;
    last_busy = -1;
    done_at   = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      #1;
      if (clear_busy) begin
        busy_cnt++;
        last_busy = i;
      end
      if (clear_done) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
      clear_req     = (i == second_req_at);
      reg_write     = (i == write_at);
      write_address = wa;
      write_data    = wd;
    end
    reg_write = 1'b0;
    clear_req = 1'b0;
  endtask

  initial begin
    int busy_cnt, done_cnt, last_busy, done_at, seen;

    vecs[0]  = '{1'b1, 5'd4,  32'd22,        5'd4,  5'd5,  32'd22,        32'd0};
    vecs[1]  = '{1'b1, 5'd5,  32'd23,        5'd4,  5'd5,  32'd22,        32'd23};
    vecs[2]  = '{1'b0, 5'd0,  32'd0,         5'd4,  5'd5,  32'd22,        32'd23};
    vecs[3]  = '{1'b1, 5'd0,  32'h0000FFFF,  5'd0,  5'd0,  32'd0,         32'd0};
    vecs[4]  = '{1'b0, 5'd0,  32'd0,         5'd0,  5'd4,  32'd0,         32'd22};
    vecs[5]  = '{1'b1, 5'd7,  32'h000000A5,  5'd6,  5'd7,  32'd0,         32'h000000A5};
    vecs[6]  = '{1'b0, 5'd0,  32'd0,         5'd7,  5'd7,  32'h000000A5,  32'h000000A5};
    vecs[7]  = '{1'b1, 5'd4,  32'h00001234,  5'd4,  5'd5,  32'h00001234,  32'd23};
    vecs[8]  = '{1'b0, 5'd0,  32'd0,         5'd4,  5'd31, 32'h00001234,  32'd0};
    vecs[9]  = '{1'b1, 5'd31, 32'hFFFFFFFF,  5'd31, 5'd30, 32'hFFFFFFFF,  32'd0};
    vecs[10] = '{1'b0, 5'd0,  32'd0,         5'd31, 5'd0,  32'hFFFFFFFF,  32'd0};

    rst       = 1'b0;
    clear_req = 1'b0;
    apply_stimulus(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    #100;
    @(negedge clk);
    rst = 1'b1;

    // Reset state: every register reads zero, clear engine idle.
    #1;
    check_output("reset_busy", {31'd0, clear_busy}, 32'd0);
    check_output("reset_done", {31'd0, clear_done}, 32'd0);
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a);
      ra1 = 5'(31 - a);
      #1;
      check_output($sformatf("reset_p0_r%0d", a), read_data[31:0], 32'd0);
      check_output($sformatf("reset_p1_r%0d", 31 - a), read_data[63:32], 32'd0);
    end

    for (int v = 0; v < 11; v++) begin
      @(negedge clk);
      apply_stimulus(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra0, vecs[v].ra1);
      #1;
      check_output($sformatf("vec%0d_p0", v), read_data[31:0], vecs[v].exp0);
      check_output($sformatf("vec%0d_p1", v), read_data[63:32], vecs[v].exp1);
    end

    // Fill 1..31 with their index, then clear with a write to 9 dropped mid-sequence.
    for (int a = 1; a < 32; a++) begin
      @(negedge clk);
      apply_stimulus(1'b1, 5'(a), 32'(a), 5'd0, 5'd0);
    end
    @(negedge clk);
    apply_stimulus(1'b0, 5'd0, 32'd0, 5'd17, 5'd9);
    #1;
    check_output("fill_r17", read_data[31:0], 32'd17);
    check_output("fill_r9", read_data[63:32], 32'd9);
    clear_req = 1'b1;
    clear_window(-1, 20, 5'd9, 32'h55, busy_cnt, done_cnt, last_busy, done_at);
    check_output("clr1_busy_cycles", 32'(busy_cnt), 32'd32);
    check_output("clr1_done_pulses", 32'(done_cnt), 32'd1);
    check_output("clr1_done_follows_busy", 32'(done_at), 32'(last_busy + 1));
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a);
      ra1 = 5'(31 - a);
      #1;
      check_output($sformatf("clr1_p0_r%0d", a), read_data[31:0], 32'd0);
      check_output($sformatf("clr1_p1_r%0d", 31 - a), read_data[63:32], 32'd0);
    end

    // Re-request while busy is ignored; a write coinciding with the request is wiped.
    @(negedge clk);
    apply_stimulus(1'b1, 5'd3, 32'h11, 5'd3, 5'd0);
    clear_req = 1'b1;
    #1;
    check_output("clr2_bypass_r3", read_data[31:0], 32'h11);
    clear_window(5, -1, 5'd0, 32'd0, busy_cnt, done_cnt, last_busy, done_at);
    check_output("clr2_busy_cycles", 32'(busy_cnt), 32'd32);
    check_output("clr2_done_pulses", 32'(done_cnt), 32'd1);
    check_output("clr2_done_follows_busy", 32'(done_at), 32'(last_busy + 1));
    ra0 = 5'd3;
    #1;
    check_output("clr2_r3_cleared", read_data[31:0], 32'd0);

    // Reset in the 10th busy cycle aborts the sequence with no completion pulse.
    @(negedge clk);
    apply_stimulus(1'b1, 5'd12, 32'h77, 5'd12, 5'd0);
    @(negedge clk);
    apply_stimulus(1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    #1;
    check_output("abort_pre_r12", read_data[31:0], 32'h77);
    clear_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 40 && seen < 10; i++) begin
      @(negedge clk);
      clear_req = 1'b0;
      #1;
      if (clear_busy) seen++;
    end
    check_output("abort_reached_10", 32'(seen), 32'd10);
    rst = 1'b0;
    #1;
    check_output("abort_busy", {31'd0, clear_busy}, 32'd0);
    check_output("abort_done", {31'd0, clear_done}, 32'd0);
    check_output("abort_r12", read_data[31:0], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (clear_busy) busy_cnt++;
      if (clear_done) done_cnt++;
    end
    check_output("abort_no_busy_after", 32'(busy_cnt), 32'd0);
    check_output("abort_no_done_after", 32'(done_cnt), 32'd0);
    @(negedge clk);
    apply_stimulus(1'b1, 5'd6, 32'h66, 5'd6, 5'd12);
    @(negedge clk);
    apply_stimulus(1'b0, 5'd0, 32'd0, 5'd6, 5'd12);
    #1;
    check_output("post_abort_r6", read_data[31:0], 32'h66);
    check_output("post_abort_r12", read_data[63:32], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
